// File: rtl/branch_predictor_if.sv
// Fetch/EX-facing bundle of the branch predictor: combinational lookup,
// resolve/update, mispredict flag and table flush.
interface branch_predictor_if;
   logic        lookup_en;
   logic [31:0] lookup_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        mispredict;
   logic        flush_table;

   modport master (
      output lookup_en, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
             upd_pred_taken, upd_pred_target, flush_table,
      input  pred_taken, pred_target, mispredict
   );

   modport slave (
      input  lookup_en, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
             upd_pred_taken, upd_pred_target, flush_table,
      output pred_taken, pred_target, mispredict
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters,
// a mispredict detector for the hazard unit and saturating perf counters.
module branch_predictor #(
   parameter int INDEX_BITS = 4,
   parameter int CTR_BITS   = 2,
   parameter int MODE       = 1,
   parameter int PERF_BITS  = 32
) (
   input  logic                 CLK,
   input  logic                 nRST,
   branch_predictor_if.slave    bp,
   output logic [PERF_BITS-1:0] perf_lookups,
   output logic [PERF_BITS-1:0] perf_mispredicts
);
   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;
   localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));
   localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_BITS'(1);
   localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;

   logic                valid_q  [ENTRIES];
   logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];

   logic [INDEX_BITS-1:0] lk_idx;
   logic [TAG_BITS-1:0]   lk_tag;
   logic                  lk_hit;
   logic [INDEX_BITS-1:0] up_idx;
   logic [TAG_BITS-1:0]   up_tag;
   logic                  up_hit;
   logic                  unused_pc_bits;

   assign lk_idx = bp.lookup_pc[INDEX_BITS+1:2];
   assign lk_tag = bp.lookup_pc[31:INDEX_BITS+2];
   assign up_idx = bp.upd_pc[INDEX_BITS+1:2];
   assign up_tag = bp.upd_pc[31:INDEX_BITS+2];
   assign unused_pc_bits = ^{bp.lookup_pc[1:0], bp.upd_pc[1:0]};

   // Lookup reads pre-edge contents; no bypass from a same-cycle update.
   always_comb begin
      lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      bp.pred_taken  = (MODE == 1) && lk_hit && ctr_q[lk_idx][CTR_BITS-1];
      bp.pred_target = bp.pred_taken ? target_q[lk_idx] : bp.lookup_pc + 32'd4;
   end

   always_comb begin
      bp.mispredict = 1'b0;
      if (bp.upd_valid) begin
         bp.mispredict = (bp.upd_taken != bp.upd_pred_taken) ||
                         (bp.upd_taken && (bp.upd_target != bp.upd_pred_target));
      end
   end

   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= CTR_WEAK_NT;
         end
         perf_lookups     <= '0;
         perf_mispredicts <= '0;
      end else begin
         if (bp.lookup_en && (perf_lookups != '1))
            perf_lookups <= perf_lookups + PERF_BITS'(1);
         if (bp.mispredict && (perf_mispredicts != '1))
            perf_mispredicts <= perf_mispredicts + PERF_BITS'(1);

         if (bp.flush_table) begin
            for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
         end else if (bp.upd_valid) begin
            if (up_hit) begin
               if (bp.upd_taken && (ctr_q[up_idx] != CTR_MAX))
                  ctr_q[up_idx] <= ctr_q[up_idx] + CTR_BITS'(1);
               else if (!bp.upd_taken && (ctr_q[up_idx] != '0))
                  ctr_q[up_idx] <= ctr_q[up_idx] - CTR_BITS'(1);
            end else if (bp.upd_taken) begin
               valid_q[up_idx] <= 1'b1;
               ctr_q[up_idx]   <= CTR_WEAK_T;
            end
         end
      end
   end

   // Tag/target need no reset; any taken update (hit or allocate) rewrites both.
   always_ff @(posedge CLK) begin
      if (nRST && !bp.flush_table && bp.upd_valid && bp.upd_taken) begin
         tag_q[up_idx]    <= up_tag;
         target_q[up_idx] <= bp.upd_target;
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: vector table through a scoreboard on a dynamic
// instance, plus hand sequences for reset, static mode and perf saturation.
module tb_branch_predictor;
   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   branch_predictor_if bp_d ();
   branch_predictor_if bp_s ();
   logic [31:0] d_lookups, d_mis;
   logic [3:0]  s_lookups, s_mis;

   branch_predictor #(.INDEX_BITS(4), .CTR_BITS(2), .MODE(1), .PERF_BITS(32)) u_dyn (
      .CLK(CLK), .nRST(nRST), .bp(bp_d),
      .perf_lookups(d_lookups), .perf_mispredicts(d_mis));

   branch_predictor #(.INDEX_BITS(4), .CTR_BITS(2), .MODE(0), .PERF_BITS(4)) u_stat (
      .CLK(CLK), .nRST(nRST), .bp(bp_s),
      .perf_lookups(s_lookups), .perf_mispredicts(s_mis));

   typedef struct {
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utgt;
      logic        upt;
      logic [31:0] uptgt;
      logic        flush;
      logic        len;
      logic [31:0] lpc;
      logic        e_taken;
      logic [31:0] e_target;
      logic        e_mis;
   } vec_t;

   typedef struct {
      logic        taken;
      logic [31:0] target;
      logic        mis;
      logic [31:0] lookups;
      logic [31:0] mispredicts;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] m_lookups = 0;
   logic [31:0] m_mis = 0;

   function automatic vec_t mk(logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt,
                               logic upt, logic [31:0] uptgt, logic flush, logic len,
                               logic [31:0] lpc, logic e_taken, logic [31:0] e_target,
                               logic e_mis);
      vec_t v;
      v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt; v.uptgt = uptgt;
      v.flush = flush; v.len = len; v.lpc = lpc;
      v.e_taken = e_taken; v.e_target = e_target; v.e_mis = e_mis;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_d(vec_t v);
      bp_d.upd_valid       = v.uv;
      bp_d.upd_pc          = v.upc;
      bp_d.upd_taken       = v.ut;
      bp_d.upd_target      = v.utgt;
      bp_d.upd_pred_taken  = v.upt;
      bp_d.upd_pred_target = v.uptgt;
      bp_d.flush_table     = v.flush;
      bp_d.lookup_en       = v.len;
      bp_d.lookup_pc       = v.lpc;
   endtask

   task automatic drive_s(logic uv, logic [31:0] pc, logic ut, logic [31:0] tgt,
                          logic upt, logic [31:0] uptgt, logic len);
      bp_s.upd_valid       = uv;
      bp_s.upd_pc          = pc;
      bp_s.upd_taken       = ut;
      bp_s.upd_target      = tgt;
      bp_s.upd_pred_taken  = upt;
      bp_s.upd_pred_target = uptgt;
      bp_s.flush_table     = 1'b0;
      bp_s.lookup_en       = len;
      bp_s.lookup_pc       = pc;
   endtask

   initial begin
      vec_t idle;
      exp_t e;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 0, 32'h44, 0);

      // upd: valid pc taken target pred_taken pred_target | flush len lookup_pc | exp
      vecs.push_back(mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h40,  0, 32'h44,  0));
      vecs.push_back(mk(1, 32'h40,  1, 32'h100, 0, 32'h44,  0, 1, 32'h40,  0, 32'h44,  1));
      vecs.push_back(mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h40,  1, 32'h100, 0));
      vecs.push_back(mk(1, 32'h40,  1, 32'h100, 1, 32'h100, 0, 1, 32'h40,  1, 32'h100, 0));
      vecs.push_back(mk(1, 32'h40,  1, 32'h100, 1, 32'h100, 0, 1, 32'h40,  1, 32'h100, 0));
      vecs.push_back(mk(1, 32'h40,  1, 32'h100, 1, 32'h100, 0, 1, 32'h40,  1, 32'h100, 0));
      vecs.push_back(mk(1, 32'h40,  0, 32'h0,   1, 32'h100, 0, 1, 32'h40,  1, 32'h100, 1));
      vecs.push_back(mk(1, 32'h40,  0, 32'h0,   1, 32'h100, 0, 1, 32'h40,  1, 32'h100, 1));
      vecs.push_back(mk(1, 32'h40,  0, 32'h0,   0, 32'h44,  0, 1, 32'h40,  0, 32'h44,  0));
      vecs.push_back(mk(1, 32'h40,  0, 32'h0,   0, 32'h44,  0, 1, 32'h40,  0, 32'h44,  0));
      vecs.push_back(mk(1, 32'h40,  1, 32'h100, 0, 32'h44,  0, 1, 32'h40,  0, 32'h44,  1));
      vecs.push_back(mk(1, 32'h40,  1, 32'h180, 0, 32'h44,  0, 1, 32'h40,  0, 32'h44,  1));
      vecs.push_back(mk(1, 32'h40,  1, 32'h1c0, 1, 32'h180, 0, 1, 32'h40,  1, 32'h180, 1));
      vecs.push_back(mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h43,  1, 32'h1c0, 0));
      // aliasing at index 0 and miss/not-taken leaving the entry alone
      vecs.push_back(mk(1, 32'h440, 1, 32'h200, 0, 32'h444, 0, 1, 32'h440, 0, 32'h444, 1));
      vecs.push_back(mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h40,  0, 32'h44,  0));
      vecs.push_back(mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h440, 1, 32'h200, 0));
      vecs.push_back(mk(1, 32'h40,  0, 32'h0,   0, 32'h44,  0, 1, 32'h440, 1, 32'h200, 0));
      vecs.push_back(mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h440, 1, 32'h200, 0));
      // same-cycle allocate/lookup, then flush racing an update
      vecs.push_back(mk(1, 32'h80,  1, 32'h300, 0, 32'h84,  0, 1, 32'h80,  0, 32'h84,  1));
      vecs.push_back(mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h80,  1, 32'h300, 0));
      vecs.push_back(mk(1, 32'h90,  1, 32'h400, 0, 32'h94,  1, 1, 32'h80,  1, 32'h300, 1));
      vecs.push_back(mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h90,  0, 32'h94,  0));
      vecs.push_back(mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 32'h80,  0, 32'h84,  0));
      vecs.push_back(mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h440, 0, 32'h444, 0));
      vecs.push_back(mk(0, 32'hx,   1'bx, 32'hx, 1'bx, 32'hx, 0, 0, 32'h40, 0, 32'h44, 0));

      nRST = 1'b0;
      drive_d(idle);
      drive_s(0, 32'h40, 0, 0, 0, 0, 0);
      repeat (2) @(posedge CLK);
      #1 nRST = 1'b1;
      @(negedge CLK);
      check("reset d_lookups", d_lookups, 0);
      check("reset d_mis", d_mis, 0);
      check("reset pred_taken", {31'b0, bp_d.pred_taken}, 0);
      check("reset pred_target", bp_d.pred_target, 32'h44);
      check("reset mispredict", {31'b0, bp_d.mispredict}, 0);

      for (int k = 0; k < vecs.size(); k++) begin
         @(posedge CLK);
         #1;
         drive_d(vecs[k]);
         e.taken = vecs[k].e_taken;
         e.target = vecs[k].e_target;
         e.mis = vecs[k].e_mis;
         e.lookups = m_lookups;
         e.mispredicts = m_mis;
         sb.push_back(e);
         m_lookups = m_lookups + {31'b0, vecs[k].len};
         m_mis = m_mis + {31'b0, vecs[k].e_mis};
         @(negedge CLK);
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard empty at vector %0d", k);
         end else begin
            e = sb.pop_front();
            check($sformatf("v%0d pred_taken", k), {31'b0, bp_d.pred_taken}, {31'b0, e.taken});
            check($sformatf("v%0d pred_target", k), bp_d.pred_target, e.target);
            check($sformatf("v%0d mispredict", k), {31'b0, bp_d.mispredict}, {31'b0, e.mis});
            check($sformatf("v%0d perf_lookups", k), d_lookups, e.lookups);
            check($sformatf("v%0d perf_mispredicts", k), d_mis, e.mispredicts);
         end
      end

      // reset coinciding with an update drops it; mispredict stays combinational
      @(posedge CLK);
      #1;
      nRST = 1'b0;
      drive_d(mk(1, 32'h40, 1, 32'h500, 0, 32'h44, 0, 1, 32'h40, 0, 0, 0));
      @(negedge CLK);
      check("mispredict in reset", {31'b0, bp_d.mispredict}, 1);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      drive_d(idle);
      @(negedge CLK);
      check("post-reset pred_taken", {31'b0, bp_d.pred_taken}, 0);
      check("post-reset pred_target", bp_d.pred_target, 32'h44);
      check("post-reset d_lookups", d_lookups, 0);
      check("post-reset d_mis", d_mis, 0);

      // static instance: trained taken but never predicts; perf saturates at 15
      for (int k = 0; k < 20; k++) begin
         @(posedge CLK);
         #1;
         drive_s(1, 32'h40, 1, 32'h100, 0, 32'h44, 1);
         @(negedge CLK);
         if (k < 4) begin
            check($sformatf("static c%0d pred_taken", k), {31'b0, bp_s.pred_taken}, 0);
            check($sformatf("static c%0d pred_target", k), bp_s.pred_target, 32'h44);
            check($sformatf("static c%0d mispredict", k), {31'b0, bp_s.mispredict}, 1);
         end
         check($sformatf("static c%0d perf_mis", k), {28'b0, s_mis}, (k > 15) ? 15 : k);
      end
      @(posedge CLK);
      #1;
      drive_s(0, 32'h40, 0, 0, 0, 0, 0);
      @(negedge CLK);
      check("static perf_mis sat", {28'b0, s_mis}, 15);
      check("static perf_lookups sat", {28'b0, s_lookups}, 15);
      check("static idle mispredict", {31'b0, bp_s.mispredict}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
